// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register: captures decoded ID-stage fields each cycle and
// presents the EX stage with the ALU opcode and the selected a/b operands.
module idex_pipe_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         stall,
  input  logic         flush,
  input  logic         dwreg,
  input  logic         dm2reg,
  input  logic         dwmem,
  input  logic [3:0]   daluc,
  input  logic         daluimm,
  input  logic         dshift,
  input  logic         dsext,
  input  logic [W-1:0] dina,
  input  logic [W-1:0] dinb,
  input  logic [15:0]  dimm,
  input  logic [4:0]   dsa,
  input  logic [4:0]   drn,
  output logic         evalid,
  output logic         ewreg,
  output logic         em2reg,
  output logic         ewmem,
  output logic [3:0]   ealuc,
  output logic [W-1:0] ea,
  output logic [W-1:0] eb,
  output logic [W-1:0] estore,
  output logic [4:0]   ern
);

  logic         r_valid;
  logic         r_wreg;
  logic         r_m2reg;
  logic         r_wmem;
  logic [3:0]   r_aluc;
  logic         r_aluimm;
  logic         r_shift;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] r_imm;
  logic [4:0]   r_sa;
  logic [4:0]   r_rn;

  logic [W-1:0] w_immExt;

  // Extension happens at capture so EX only sees a ready-made W-bit immediate.
  assign w_immExt = dsext ? {{(W-16){dimm[15]}}, dimm} : {{(W-16){1'b0}}, dimm};

  always_ff @(posedge clk) begin
    if (!clrn || flush) begin
      r_valid  <= 1'b0;
      r_wreg   <= 1'b0;
      r_m2reg  <= 1'b0;
      r_wmem   <= 1'b0;
      r_aluc   <= 4'd0;
      r_aluimm <= 1'b0;
      r_shift  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_imm    <= '0;
      r_sa     <= 5'd0;
      r_rn     <= 5'd0;
    end else if (!stall) begin
      r_valid  <= 1'b1;
      r_wreg   <= dwreg;
      r_m2reg  <= dm2reg;
      r_wmem   <= dwmem;
      r_aluc   <= daluc;
      r_aluimm <= daluimm;
      r_shift  <= dshift;
      r_a      <= dina;
      r_b      <= dinb;
      r_imm    <= w_immExt;
      r_sa     <= dsa;
      r_rn     <= drn;
    end
  end

  // A bubble clears every field, so the ALU sees add with 0+0 and no side effects.
  assign evalid = r_valid;
  assign ewreg  = r_wreg;
  assign em2reg = r_m2reg;
  assign ewmem  = r_wmem;
  assign ealuc  = r_aluc;
  assign ern    = r_rn;
  assign ea     = r_shift ? {{(W-5){1'b0}}, r_sa} : r_a;
  assign eb     = r_aluimm ? r_imm : r_b;
  assign estore = r_b;

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Randomized scoreboard bench for idex_pipe_reg: the stimulus side pushes the
// expected EX view per edge, a monitor pops and compares after each edge.
module tb_idex_pipe_reg;

  localparam int W = 32;

  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic [3:0]  aluc;
    logic        aluimm;
    logic        shift;
    logic        sext;
    logic [31:0] ina;
    logic [31:0] inb;
    logic [15:0] imm;
    logic [4:0]  sa;
    logic [4:0]  rn;
  } inT;

  typedef struct packed {
    logic        valid;
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic [3:0]  aluc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] store;
    logic [4:0]  rn;
  } outT;

  logic         clk = 1'b0;
  logic         clrn, stall, flush;
  logic         dwreg, dm2reg, dwmem, daluimm, dshift, dsext;
  logic [3:0]   daluc;
  logic [W-1:0] dina, dinb;
  logic [15:0]  dimm;
  logic [4:0]   dsa, drn;
  logic         evalid, ewreg, em2reg, ewmem;
  logic [3:0]   ealuc;
  logic [W-1:0] ea, eb, estore;
  logic [4:0]   ern;

  int  testsRun = 0;
  int  failures = 0;
  outT modelOut = '0;
  outT expQ[$];

  idex_pipe_reg #(.W(W)) dut (
    .clk(clk), .clrn(clrn), .stall(stall), .flush(flush),
    .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem), .daluc(daluc),
    .daluimm(daluimm), .dshift(dshift), .dsext(dsext),
    .dina(dina), .dinb(dinb), .dimm(dimm), .dsa(dsa), .drn(drn),
    .evalid(evalid), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .ealuc(ealuc), .ea(ea), .eb(eb), .estore(estore), .ern(ern)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference: what the EX stage should show for an instruction as decoded.
  function automatic outT instrView(input inT in);
    outT o;
    logic [31:0] immVal;
    immVal = {16'd0, in.imm};
    if (in.sext && in.imm >= 16'h8000) immVal = immVal + 32'hFFFF_0000;
    o.valid = 1'b1;
    o.wreg  = in.wreg;
    o.m2reg = in.m2reg;
    o.wmem  = in.wmem;
    o.aluc  = in.aluc;
    o.a     = in.shift ? 32'(in.sa) : in.ina;
    o.b     = in.aluimm ? immVal : in.inb;
    o.store = in.inb;
    o.rn    = in.rn;
    return o;
  endfunction

  function automatic inT randIn();
    inT r;
    r.wreg   = 1'($urandom);
    r.m2reg  = 1'($urandom);
    r.wmem   = 1'($urandom);
    r.aluc   = 4'($urandom);
    r.aluimm = 1'($urandom);
    r.shift  = 1'($urandom);
    r.sext   = 1'($urandom);
    r.ina    = $urandom;
    r.inb    = $urandom;
    r.imm    = 16'($urandom);
    r.sa     = 5'($urandom);
    r.rn     = 5'($urandom);
    return r;
  endfunction

  // Drive one cycle's inputs on the falling edge, then record the expected
  // post-edge view once the rising edge has been taken.
  task automatic applyStimulus(input inT in, input logic rst, input logic stl, input logic fl);
    @(negedge clk);
    clrn = ~rst; stall = stl; flush = fl;
    dwreg = in.wreg; dm2reg = in.m2reg; dwmem = in.wmem; daluc = in.aluc;
    daluimm = in.aluimm; dshift = in.shift; dsext = in.sext;
    dina = in.ina; dinb = in.inb; dimm = in.imm; dsa = in.sa; drn = in.rn;
    @(posedge clk);
    if (rst || fl) modelOut = '0;
    else if (!stl) modelOut = instrView(in);
    expQ.push_back(modelOut);
  endtask

  initial begin : monitor
    outT e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("evalid", 32'(evalid), 32'(e.valid));
        checkOutput("ewreg",  32'(ewreg),  32'(e.wreg));
        checkOutput("em2reg", 32'(em2reg), 32'(e.m2reg));
        checkOutput("ewmem",  32'(ewmem),  32'(e.wmem));
        checkOutput("ealuc",  32'(ealuc),  32'(e.aluc));
        checkOutput("ea",     ea,          e.a);
        checkOutput("eb",     eb,          e.b);
        checkOutput("estore", estore,      e.store);
        checkOutput("ern",    32'(ern),    32'(e.rn));
      end
    end
  end

  initial begin
    inT x;
    inT ones;
    ones = '1;
    clrn = 1'b0; stall = 1'b0; flush = 1'b0;
    {dwreg, dm2reg, dwmem, daluimm, dshift, dsext} = '0;
    daluc = '0; dina = '0; dinb = '0; dimm = '0; dsa = '0; drn = '0;

    // Reset with all-ones inputs, then release and load them.
    applyStimulus(ones, 1'b1, 1'b0, 1'b0);
    applyStimulus(ones, 1'b1, 1'b0, 1'b0);
    #2 checkOutput("resetEb", eb, 32'd0);
    applyStimulus(ones, 1'b0, 1'b0, 1'b0);
    #2 checkOutput("releaseEa", ea, 32'd31);

    // Immediate extension, both modes.
    x = randIn(); x.imm = 16'h8001; x.aluimm = 1'b1; x.sext = 1'b1;
    applyStimulus(x, 1'b0, 1'b0, 1'b0);
    #2 checkOutput("signExtEb", eb, 32'hFFFF_8001);
    x.sext = 1'b0;
    applyStimulus(x, 1'b0, 1'b0, 1'b0);
    #2 checkOutput("zeroExtEb", eb, 32'h0000_8001);
    checkOutput("zeroExtStore", estore, x.inb);

    // Shift-amount select and its bypass.
    x = randIn(); x.shift = 1'b1; x.sa = 5'd31; x.ina = 32'h1234_5678; x.aluc = 4'd3;
    applyStimulus(x, 1'b0, 1'b0, 1'b0);
    #2 checkOutput("shiftEa", ea, 32'd31);
    x.shift = 1'b0;
    applyStimulus(x, 1'b0, 1'b0, 1'b0);
    #2 checkOutput("noShiftEa", ea, 32'h1234_5678);

    // Stall for 3 edges with changing inputs, then resume.
    applyStimulus(randIn(), 1'b0, 1'b0, 1'b0);
    repeat (3) applyStimulus(randIn(), 1'b0, 1'b1, 1'b0);
    applyStimulus(randIn(), 1'b0, 1'b0, 1'b0);

    // Flush beats stall.
    x = randIn(); x.wreg = 1'b1; x.wmem = 1'b1; x.rn = 5'd7;
    applyStimulus(x, 1'b0, 1'b0, 1'b0);
    applyStimulus(randIn(), 1'b0, 1'b1, 1'b1);
    #2 checkOutput("flushValid", 32'(evalid), 32'd0);

    // Reset in the middle of a stall.
    applyStimulus(randIn(), 1'b0, 1'b0, 1'b0);
    applyStimulus(randIn(), 1'b0, 1'b1, 1'b0);
    applyStimulus(randIn(), 1'b1, 1'b1, 1'b0);

    // Streaming of 8 distinct instructions.
    for (int i = 0; i < 8; i++) begin
      x = randIn(); x.rn = 5'(i + 1);
      applyStimulus(x, 1'b0, 1'b0, 1'b0);
    end

    // Random mix of loads, stalls, flushes and resets.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(randIn(), ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
    end

    @(negedge clk);
    @(negedge clk);
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
